// File: rtl/capture_mem_pkg.sv
// capture_mem_pkg: shared types and constants for the capture memory arbiter.
//   Holds the arbiter FSM state enum, the packets-per-word constants and the
//   word-FIFO entry struct. The widths here set the layout of FIFO entries and
//   must match the parameters the top is built with.
package capture_mem_pkg;
    localparam int DEF_SAMPLE_PACKET_WIDTH = 32;
    localparam int DEF_MEM_DATA_WIDTH      = 128;
    localparam int DEF_MEM_ADDR_WIDTH      = 28;
    localparam int PPW                     = DEF_MEM_DATA_WIDTH / DEF_SAMPLE_PACKET_WIDTH;
    localparam int LOG2_PPW                = $clog2(PPW);

    typedef enum logic [1:0] {IDLE, WR_CMD, RD_CMD, RD_WAIT} arb_state_e;

    typedef struct packed {
        logic [DEF_MEM_ADDR_WIDTH-1:0] addr;
        logic [DEF_MEM_DATA_WIDTH-1:0] data;
    } word_entry_t;
endpackage

// File: rtl/capture_word_fifo.sv
// capture_word_fifo: 2-entry synchronous FIFO of packed memory words.
//   clk, reset   clock, synchronous active-high reset
//   push_i/din_i write an entry; accepted when not full, or when full and popping
//   pop_i/dout_o dout_o is the head entry, removed on pop_i when not empty
//   full_o, empty_o, count_o  occupancy
module capture_word_fifo
    import capture_mem_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        push_i,
    input  word_entry_t din_i,
    input  logic        pop_i,
    output word_entry_t dout_o,
    output logic        full_o,
    output logic        empty_o,
    output logic [1:0]  count_o
);
    word_entry_t mem_q [2];
    logic        wptr_q, rptr_q;
    logic [1:0]  count_q;
    logic        do_push, do_pop;

    assign do_pop  = pop_i && count_q != 2'd0;
    assign do_push = push_i && (count_q != 2'd2 || do_pop);
    assign dout_o  = mem_q[rptr_q];
    assign full_o  = count_q == 2'd2;
    assign empty_o = count_q == 2'd0;
    assign count_o = count_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr_q  <= 1'b0;
            rptr_q  <= 1'b0;
            count_q <= 2'd0;
        end else begin
            if (do_push) begin
                mem_q[wptr_q] <= din_i;
                wptr_q        <= !wptr_q;
            end
            if (do_pop)
                rptr_q <= !rptr_q;
            count_q <= count_q + 2'(do_push) - 2'(do_pop);
        end
    end
endmodule

// File: rtl/capture_mem_arbiter.sv
// capture_mem_arbiter: packs capture packets into memory words and shares the
//   memory command port between capture writes and readback reads.
//   clk, reset                  clock, synchronous active-high reset
//   wr_valid/wr_packet/wr_sample_number  capture packet stream
//   wr_page_full                word FIFO full (registered), capture must stall
//   flush/flush_done            commit partial word / all capture data written
//   rd_req/rd_addr/rd_grant     readback word request and acceptance
//   rd_data_valid/rd_data       returned readback word (registered)
//   mem_cmd_*                   valid/ready command channel to memory
//   mem_rd_valid/mem_rd_data    read data from memory
//   ovf_count                   dropped-packet count, only with ARB_OVERFLOW_CNT_EN
module capture_mem_arbiter
    import capture_mem_pkg::*;
#(
    parameter int SAMPLE_PACKET_WIDTH = DEF_SAMPLE_PACKET_WIDTH,
    parameter int MEM_DATA_WIDTH      = DEF_MEM_DATA_WIDTH,
    parameter int MEM_ADDR_WIDTH      = DEF_MEM_ADDR_WIDTH
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           wr_valid,
    input  logic [SAMPLE_PACKET_WIDTH-1:0] wr_packet,
    input  logic [31:0]                    wr_sample_number,
    output logic                           wr_page_full,
    input  logic                           flush,
    output logic                           flush_done,
    input  logic                           rd_req,
    input  logic [MEM_ADDR_WIDTH-1:0]      rd_addr,
    output logic                           rd_grant,
    output logic                           rd_data_valid,
    output logic [MEM_DATA_WIDTH-1:0]      rd_data,
    output logic                           mem_cmd_valid,
    input  logic                           mem_cmd_ready,
    output logic                           mem_cmd_write,
    output logic [MEM_ADDR_WIDTH-1:0]      mem_cmd_addr,
    output logic [MEM_DATA_WIDTH-1:0]      mem_wr_data,
    input  logic                           mem_rd_valid,
    input  logic [MEM_DATA_WIDTH-1:0]      mem_rd_data
`ifdef ARB_OVERFLOW_CNT_EN
    , output logic [15:0]                  ovf_count
`endif
);
    arb_state_e                  state_q, state_d;
    logic                        rd_prio_q, rd_prio_d;
    logic [LOG2_PPW:0]           cnt_q, cnt_d;
    logic [MEM_DATA_WIDTH-1:0]   data_q, data_d, pdata, rd_data_q;
    logic [MEM_ADDR_WIDTH-1:0]   addr_q, addr_d, paddr;
    logic                        flush_pend_q, flush_pend_d, done_wait_q, done_wait_d;
    logic                        flush_done_q, page_full_q, rd_valid_q;
    logic                        full_word, can_push, flush_req, held, done_cond;
    logic                        fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [1:0]                  fifo_count;
    word_entry_t                 head;

    capture_word_fifo u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (fifo_push),
        .din_i   ('{addr: paddr, data: pdata}),
        .pop_i   (fifo_pop),
        .dout_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // The incoming packet is merged before deciding, so a flush in the same
    // cycle includes it and a completing packet carries the held lanes.
    always_comb begin
        pdata = data_q;
        if (wr_valid)
            pdata[cnt_q*SAMPLE_PACKET_WIDTH +: SAMPLE_PACKET_WIDTH] = wr_packet;
        paddr     = cnt_q == '0 ? MEM_ADDR_WIDTH'(wr_sample_number >> LOG2_PPW) : addr_q;
        full_word = wr_valid && cnt_q == (LOG2_PPW+1)'(PPW-1);
        can_push  = !fifo_full || fifo_pop;
        flush_req = flush || flush_pend_q;
        held      = cnt_q != '0 || wr_valid;
        fifo_push = can_push && (full_word || (flush_req && held));
        cnt_d     = cnt_q;
        data_d    = data_q;
        addr_d    = addr_q;
        if (fifo_push) begin
            cnt_d  = '0;
            data_d = '0;
        end else if (wr_valid && !full_word) begin
            cnt_d  = cnt_q + 1'b1;
            data_d = pdata;
            addr_d = paddr;
        end
        // A flush that cannot push yet (FIFO full) stays pending until it can.
        flush_pend_d = flush_req && held && !fifo_push;
        // A non-empty FIFO covers any write sitting in WR_CMD.
        done_cond    = done_wait_q && fifo_empty && cnt_q == '0 && !flush_pend_q;
        done_wait_d  = (done_wait_q && !done_cond) || flush;
    end

    always_comb begin
        state_d       = state_q;
        rd_prio_d     = rd_prio_q;
        mem_cmd_valid = 1'b0;
        mem_cmd_write = 1'b0;
        mem_cmd_addr  = '0;
        mem_wr_data   = '0;
        rd_grant      = 1'b0;
        fifo_pop      = 1'b0;
        case (state_q)
            IDLE: begin
                if (fifo_count == 2'd2 || (!fifo_empty && !(rd_req && rd_prio_q))) begin
                    state_d   = WR_CMD;
                    rd_prio_d = 1'b1;
                end else if (rd_req) begin
                    state_d   = RD_CMD;
                    rd_prio_d = 1'b0;
                end
            end
            WR_CMD: begin
                mem_cmd_valid = 1'b1;
                mem_cmd_write = 1'b1;
                mem_cmd_addr  = head.addr;
                mem_wr_data   = head.data;
                fifo_pop      = mem_cmd_ready;
                state_d       = mem_cmd_ready ? IDLE : WR_CMD;
            end
            RD_CMD: begin
                mem_cmd_valid = 1'b1;
                mem_cmd_addr  = rd_addr;
                rd_grant      = mem_cmd_ready;
                state_d       = mem_cmd_ready ? RD_WAIT : RD_CMD;
            end
            default: state_d = mem_rd_valid ? IDLE : RD_WAIT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            rd_prio_q    <= 1'b0;
            cnt_q        <= '0;
            data_q       <= '0;
            addr_q       <= '0;
            flush_pend_q <= 1'b0;
            done_wait_q  <= 1'b0;
            flush_done_q <= 1'b0;
            page_full_q  <= 1'b0;
            rd_valid_q   <= 1'b0;
            rd_data_q    <= '0;
        end else begin
            state_q      <= state_d;
            rd_prio_q    <= rd_prio_d;
            cnt_q        <= cnt_d;
            data_q       <= data_d;
            addr_q       <= addr_d;
            flush_pend_q <= flush_pend_d;
            done_wait_q  <= done_wait_d;
            flush_done_q <= done_cond;
            page_full_q  <= fifo_full;
            rd_valid_q   <= state_q == RD_WAIT && mem_rd_valid;
            if (state_q == RD_WAIT && mem_rd_valid)
                rd_data_q <= mem_rd_data;
        end
    end

    assign wr_page_full  = page_full_q;
    assign flush_done    = flush_done_q;
    assign rd_data_valid = rd_valid_q;
    assign rd_data       = rd_data_q;

`ifdef ARB_OVERFLOW_CNT_EN
    logic [15:0] ovf_q;

    always_ff @(posedge clk) begin
        if (reset)
            ovf_q <= '0;
        else if (full_word && !can_push && ovf_q != 16'hFFFF)
            ovf_q <= ovf_q + 16'd1;
    end

    assign ovf_count = ovf_q;
`endif
endmodule
